// File: rtl/vga_layer_compositor.sv
// ---------------------------------------------------------------------------
// vga_layer_compositor
//
// Three-stage pixel compositor. It merges a tile-map background with
// NUM_SPRITES prioritised sprites that can have transparent pixels.
// Channel 0 has the highest priority.
//
//   S0 (edge after the pixel is presented)
//       Registers the tile-map address and the sprite ROM address of the
//       winning sprite.
//   S1 (next edge)
//       The external memories return tile_code, spr_rgb and spr_opaque
//       while the S0 addresses are held. The tile code is passed through
//       the palette and registered, together with the sprite colour.
//   S2 (next edge)
//       Output register: the sprite colour if the winning sprite pixel is
//       opaque, otherwise the background colour.
//
// A pixel presented in cycle N appears on red/green/blue in cycle N+3.
// Sprite positions are double-buffered: game logic writes the shadow
// inputs (*_in), and frame_start copies them into the active registers.
//
// Optional build macro: VGA_COMPOSITOR_COLLISION_EN
//   Adds the output collision[NUM_SPRITES-1:0]. Bit j is set for a frame
//   when sprite 0 and sprite j were hit by the same visible pixel in the
//   previous frame.
//
// Ports:
//   clk, reset_n                   pixel clock, async active-low reset
//   frame_start                    start-of-vblank pulse; latches shadows
//   pixel_valid, row, col          pixel currently presented
//   sprite_x_in/_y_in/_en_in       shadow sprite positions and enables
//   tile_addr_row/_col, tile_code  tile-map memory interface
//   spr_index/_lx/_ly, spr_rgb,
//   spr_opaque                     sprite ROM interface
//   out_valid, red, green, blue    composited pixel
// ---------------------------------------------------------------------------
module vga_layer_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 42,
  parameter int BLOCK_WIDTH = 40,
  parameter int MAP_ROWS    = 12,
  parameter int MAP_COLS    = 17,
  parameter int COORD_W     = 11,
  parameter int COLOR_W     = 4,
  localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           frame_start,
  input  logic                           pixel_valid,
  input  logic [9:0]                     row,
  input  logic [9:0]                     col,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x_in,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y_in,
  input  logic [NUM_SPRITES-1:0]         sprite_en_in,
  output logic [3:0]                     tile_addr_row,
  output logic [4:0]                     tile_addr_col,
  input  logic [7:0]                     tile_code,
  output logic [IDX_W-1:0]               spr_index,
  output logic [5:0]                     spr_lx,
  output logic [5:0]                     spr_ly,
  input  logic [3*COLOR_W-1:0]           spr_rgb,
  input  logic                           spr_opaque,
  output logic                           out_valid,
  output logic [COLOR_W-1:0]             red,
  output logic [COLOR_W-1:0]             green,
  output logic [COLOR_W-1:0]             blue
`ifdef VGA_COMPOSITOR_COLLISION_EN
  ,
  output logic [NUM_SPRITES-1:0]         collision
`endif
);

  // One extra bit so that col - x cannot overflow for any coordinate.
  localparam int CW    = COORD_W + 1;
  localparam int RGB_W = 3 * COLOR_W;
  localparam logic signed [CW-1:0] SIZE_S = CW'(SPRITE_SIZE);
  localparam logic signed [CW-1:0] ZERO_S = '0;

  // Active (displayed) sprite registers.
  logic signed [COORD_W-1:0] act_x_reg [NUM_SPRITES];
  logic signed [COORD_W-1:0] act_y_reg [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]    act_en_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        act_x_reg[i] <= '0;
        act_y_reg[i] <= '0;
      end
      act_en_reg <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        act_x_reg[i] <= sprite_x_in[i*COORD_W +: COORD_W];
        act_y_reg[i] <= sprite_y_in[i*COORD_W +: COORD_W];
      end
      act_en_reg <= sprite_en_in;
    end
  end

  // Per-channel hit test on the sprite-local offset. For both axes,
  // 0 <= offset < SPRITE_SIZE is the same half-open box test as
  // x <= col < x + SPRITE_SIZE. Sprites that are partly off-screen clip
  // through this test without extra logic.
  logic signed [CW-1:0] col_s, row_s;
  logic [NUM_SPRITES-1:0] hit;
  logic [5:0] lx_c [NUM_SPRITES];
  logic [5:0] ly_c [NUM_SPRITES];

  assign col_s = CW'(col);
  assign row_s = CW'(row);

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
      logic signed [CW-1:0] dx, dy;
      assign dx = col_s - CW'(act_x_reg[gi]);
      assign dy = row_s - CW'(act_y_reg[gi]);
      assign hit[gi] = act_en_reg[gi] && (dx >= ZERO_S) && (dx < SIZE_S) &&
                       (dy >= ZERO_S) && (dy < SIZE_S);
      assign lx_c[gi] = dx[5:0];
      assign ly_c[gi] = dy[5:0];
    end
  endgenerate

  // Priority select. Scanning from the top channel down means the lowest
  // hitting index is assigned last and wins.
  logic             win_hit;
  logic [IDX_W-1:0] win_idx;
  logic [5:0]       win_lx, win_ly;

  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_lx  = '0;
    win_ly  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_hit = 1'b1;
        win_idx = IDX_W'(i);
        win_lx  = lx_c[i];
        win_ly  = ly_c[i];
      end
    end
  end

  // Tile coordinates. They are clamped so that a blanking-interval row or
  // column can never address outside the map.
  logic [9:0] tile_row_q, tile_col_q;
  assign tile_row_q = row / 10'(BLOCK_WIDTH);
  assign tile_col_q = col / 10'(BLOCK_WIDTH);

  // S0 stage registers.
  logic hit0_reg, valid0_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tile_addr_row <= '0;
      tile_addr_col <= '0;
      spr_index     <= '0;
      spr_lx        <= '0;
      spr_ly        <= '0;
      hit0_reg      <= 1'b0;
      valid0_reg    <= 1'b0;
    end else begin
      tile_addr_row <= (tile_row_q >= 10'(MAP_ROWS)) ? 4'(MAP_ROWS - 1) : 4'(tile_row_q);
      tile_addr_col <= (tile_col_q >= 10'(MAP_COLS)) ? 5'(MAP_COLS - 1) : 5'(tile_col_q);
      spr_index     <= win_idx;
      spr_lx        <= win_lx;
      spr_ly        <= win_ly;
      hit0_reg      <= win_hit;
      valid0_reg    <= pixel_valid;
    end
  end

  // Tile palette: converts a tile code to an {r,g,b} colour.
  function automatic logic [RGB_W-1:0] palette(input logic [7:0] code);
    case (code)
      8'd1:       palette = {COLOR_W'(0),  COLOR_W'(9),  COLOR_W'(15)};
      8'd2:       palette = {COLOR_W'(8),  COLOR_W'(4),  COLOR_W'(3)};
      8'd3:       palette = {COLOR_W'(0),  COLOR_W'(15), COLOR_W'(2)};
      8'd4:       palette = {COLOR_W'(15), COLOR_W'(13), COLOR_W'(0)};
      8'd5, 8'd6: palette = {COLOR_W'(15), COLOR_W'(15), COLOR_W'(15)};
      default:    palette = '0;
    endcase
  endfunction

  // S1 stage: memory data is captured; the sprite colour is delayed
  // alongside the palette colour so that both stay aligned.
  logic [RGB_W-1:0] pal_reg, spr_rgb_reg;
  logic             spr_opaque_reg, hit1_reg, valid1_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pal_reg        <= '0;
      spr_rgb_reg    <= '0;
      spr_opaque_reg <= 1'b0;
      hit1_reg       <= 1'b0;
      valid1_reg     <= 1'b0;
    end else begin
      pal_reg        <= palette(tile_code);
      spr_rgb_reg    <= spr_rgb;
      spr_opaque_reg <= spr_opaque;
      hit1_reg       <= hit0_reg;
      valid1_reg     <= valid0_reg;
    end
  end

  // S2 output register. A transparent winner falls back to the background
  // and never to a lower-priority sprite.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid            <= 1'b0;
      {red, green, blue}   <= '0;
    end else begin
      out_valid <= valid1_reg;
      if (!valid1_reg)
        {red, green, blue} <= '0;
      else if (hit1_reg && spr_opaque_reg)
        {red, green, blue} <= spr_rgb_reg;
      else
        {red, green, blue} <= pal_reg;
    end
  end

`ifdef VGA_COMPOSITOR_COLLISION_EN
  // Sticky per-frame overlap record. Each frame_start publishes it and
  // clears it. Bit 0 (sprite 0 against itself) is never set.
  logic [NUM_SPRITES-1:0] sticky_reg;
  localparam logic [NUM_SPRITES-1:0] NOT_BIT0 = ~NUM_SPRITES'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_reg <= '0;
      collision  <= '0;
    end else if (frame_start) begin
      collision  <= sticky_reg & NOT_BIT0;
      sticky_reg <= '0;
    end else if (pixel_valid && hit[0]) begin
      sticky_reg <= sticky_reg | (hit & NOT_BIT0);
    end
  end
`endif

endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Pipelined pixel compositor replacing the combinational drawer path; sits between the VGA timing generator and the DAC output registers.
- Merges a tile-map background with NUM_SPRITES prioritised, transparency-aware sprites.
- Sprite positions are double-buffered per frame, so game logic may update them at any time without tearing.
- Tile-map memory and sprite ROM are external synchronous-read memories addressed by this block.

Parameters:
- NUM_SPRITES, 4: number of sprite channels; index 0 has the highest priority.
- SPRITE_SIZE, 42: sprite width and height in pixels.
- BLOCK_WIDTH, 40: tile edge length in pixels.
- MAP_ROWS, 12: tile-map rows.
- MAP_COLS, 17: tile-map columns.
- COORD_W, 11: signed width of each sprite coordinate.
- COLOR_W, 4: bits per colour channel.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pixel_valid  in  1  row/col is a visible pixel this cycle
- row  in  10  pixel row, 0..479
- col  in  10  pixel column, 0..639
- sprite_x_in  in  NUM_SPRITES*COORD_W  shadow X positions (signed), channel i at [i*COORD_W +: COORD_W]
- sprite_y_in  in  NUM_SPRITES*COORD_W  shadow Y positions (signed)
- sprite_en_in  in  NUM_SPRITES  shadow enables
- tile_addr_row  out  4  tile-map read row
- tile_addr_col  out  5  tile-map read column
- tile_code  in  8  tile-map data, valid one cycle after address
- spr_index  out  clog2(NUM_SPRITES)  sprite ROM select
- spr_lx  out  6  sprite-local X
- spr_ly  out  6  sprite-local Y
- spr_rgb  in  3*COLOR_W  ROM colour {r,g,b}, valid one cycle after address
- spr_opaque  in  1  ROM pixel opaque flag
- out_valid  out  1  red/green/blue valid
- red  out  COLOR_W  red output
- green  out  COLOR_W  green output
- blue  out  COLOR_W  blue output

Behaviour:
- Reset: all pipeline registers, active sprite registers, out_valid, red, green, blue, tile_addr_*, spr_* cleared to 0.
- Shadow/active: on a cycle with frame_start=1, the active X/Y/enable registers load from *_in. Otherwise they hold.
- S0, cycle of input (registered at edge):
  - tile_addr_row = row/BLOCK_WIDTH; tile_addr_col = col/BLOCK_WIDTH.
  - Hit_i = en_i && col >= x_i && col < x_i+SPRITE_SIZE && row >= y_i && row < y_i+SPRITE_SIZE. Evaluate as signed COORD_W+1 arithmetic. Half-open bounds.
  - Winner is the lowest i with hit_i. spr_index=winner, spr_lx=col-x_winner, spr_ly=row-y_winner.
  - If there is no hit, spr_* = 0 and the hit flag is cleared.
- S1: tile_code and spr_rgb/spr_opaque arrive. The palette maps tile_code to rgb:
  - 0 border: 0,0,0
  - 1 sky: 0,9,15
  - 2 block: 8,4,3
  - 3 ground: 0,15,2
  - 4 token: 15,13,0
  - 5/6 clock: 15,15,15
  - others: 0,0,0
  Palette output is registered.
- S2 output register:
  - If the delayed hit flag is set and spr_opaque=1, output spr_rgb (delayed to align).
  - Otherwise output the palette colour.
- Latency: pixel_valid at cycle N gives out_valid at N+3. Back-to-back pixels are accepted every cycle with no stalls.
- pixel_valid=0: red/green/blue=0 and out_valid=0 at N+3 (blanking). Addresses are still issued and their data ignored.
- A transparent winning sprite pixel shows the background, not a lower-priority sprite.
- frame_start during active video: positions switch immediately. This is legal but tears; the timing generator issues it only in blank.
- Sprites partially off-screen (negative or >639 coordinates) clip naturally through the hit test.
- Reset mid-frame: pipeline flushes; the first output after release is valid only for pixels presented after release.

Optional Feature:
- Macro: VGA_COMPOSITOR_COLLISION_EN.
- When defined, the block adds output port collision [NUM_SPRITES-1:0].
  - During a frame, a sticky bit j (j≥1) sets when a pixel with pixel_valid=1 has hit_0 and hit_j both true. Bounding-box overlap of sprite 0 (player) with sprite j.
  - On frame_start, collision loads the sticky bits and the sticky bits clear. Bit 0 is always 0.
  - Reset clears both.
- When undefined, the port and logic are absent.

Test Plan:
- Reset release, all sprites disabled, tile_code=1 for all, pixel_valid held 1 → from cycle 4 on, out_valid=1 and rgb=(0,9,15); during reset all outputs are 0.
- Sprite0 at (100,200) enabled, spr_opaque=1, spr_rgb=F00:
  - col=100,row=200 → spr_lx=0, spr_ly=0, output F00 three cycles later.
  - col=142 → no hit, output is background (half-open bound).
- Sprites 0 and 1 both at (50,50) → spr_index=0. Sprite 0 pixel transparent → output is the tile palette colour, never sprite 1.
- Sprite2 at x=-10, col=0,row=y → hit with spr_lx=10. Sprite at x=630, col=639 → spr_lx=9.
- sprite_x_in changed mid-frame without frame_start → output unchanged. After a frame_start pulse → new position used on the next pixel.
- With VGA_COMPOSITOR_COLLISION_EN: sprite0 (0,0) and sprite1 (30,30) → after the next frame_start, collision=4'b0010. Sprite1 moved to (200,200) → 4'b0000 after the following frame.
